montgomery_constant_streamer: RTL and testbench

- Supplies one constant operand, k or N (typically N² for modN), block-by-block to montgomery_reduce.
- Constant is loaded once into internal BRAM, then streamed with BRAM latency hidden by a prefetch ring.
- Head block is always present on block_out. The next block appears the cycle after consumed_in.
- One instance per constant, sitting directly upstream of the reducer's k/N block inputs.

---
 rtl/montgomery_constant_streamer_if.sv | 33 +++
 rtl/montgomery_constant_streamer.sv | 224 ++++++++++++++++++++++
 tb/tb_montgomery_constant_streamer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_constant_streamer_if.sv
// Bus between the constant streamer and its neighbours (loader on one side, montgomery_reduce on the other).
// Port names match the streamer's block-level port list; the slave modport is the streamer.
interface montgomery_constant_streamer_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
);
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  // Handshakes: load_valid_in writes one block per cycle with no backpressure; consumed_in is a
  // one-cycle strobe that only takes effect while block_valid_out=1, and the next head shows one cycle later.
  logic                     load_valid_in;
  logic [REGISTER_SIZE-1:0] load_block_in;
  logic                     load_done_out;
  logic                     restart_in;
  logic                     consumed_in;
  logic [REGISTER_SIZE-1:0] block_out;
  logic                     block_valid_out;
  logic [IDX_W-1:0]         block_index_out;
  logic                     underflow_err_out;
  logic [1:0]               state_dbg_out;

  modport master (
    output load_valid_in, load_block_in, restart_in, consumed_in,
    input  load_done_out, block_out, block_valid_out, block_index_out,
    input  underflow_err_out, state_dbg_out
  );

  modport slave (
    input  load_valid_in, load_block_in, restart_in, consumed_in,
    output load_done_out, block_out, block_valid_out, block_index_out,
    output underflow_err_out, state_dbg_out
  );
endinterface

// File: rtl/montgomery_constant_streamer.sv
// Streams one Montgomery constant (k or N) block-by-block from internal BRAM through a prefetch ring.
// Optional macro MONTGOMERY_CONSTANT_STREAMER_UNDERFLOW_CHECK_EN builds the sticky consume-while-empty flag.
module montgomery_constant_streamer #(
  parameter int REGISTER_SIZE  = 32,
  parameter int NUM_BLOCKS     = 128,
  parameter int BRAM_LATENCY   = 2,
  parameter int PREFETCH_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  montgomery_constant_streamer_if.slave bus
);
  localparam int W      = REGISTER_SIZE;
  localparam int L      = BRAM_LATENCY;
  localparam int IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int FIFO_D = PREFETCH_DEPTH - 1;
  localparam int FP_W   = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = $clog2(PREFETCH_DEPTH + 1);

  if (BRAM_LATENCY < 1 || PREFETCH_DEPTH < BRAM_LATENCY + 2) begin : g_bad_cfg
    $error("PREFETCH_DEPTH must be >= BRAM_LATENCY+2 and BRAM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOADING   = 2'd1,
    ST_STREAMING = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 load_done_q, load_done_d;
  logic [IDX_W-1:0]     rd_addr_q, rd_addr_d;
  logic                 gen_q, gen_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [W-1:0]         head_data_q, head_data_d;
  logic [IDX_W-1:0]     head_idx_q, head_idx_d;
  logic                 head_valid_q, head_valid_d;
  logic [W-1:0]         fifo_data_q [FIFO_D];
  logic [W-1:0]         fifo_data_d [FIFO_D];
  logic [IDX_W-1:0]     fifo_idx_q [FIFO_D];
  logic [IDX_W-1:0]     fifo_idx_d [FIFO_D];
  logic [FP_W-1:0]      fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic [W-1:0]         mem_q [NUM_BLOCKS];
  logic                 pipe_vld_q [L];
  logic                 pipe_gen_q [L];
  logic [W-1:0]         pipe_data_q [L];
  logic [IDX_W-1:0]     pipe_idx_q [L];

  logic                 streaming, restart_evt, pop, issue, ret_ok, fifo_push, fifo_pop;
  logic [IDX_W-1:0]     wr_addr, issue_addr, ret_idx;
  logic [W-1:0]         ret_data;

  function automatic logic [IDX_W-1:0] next_addr(input logic [IDX_W-1:0] a);
    if (a == IDX_W'(NUM_BLOCKS - 1)) return '0;
    return a + IDX_W'(1);
  endfunction

  function automatic logic [FP_W-1:0] next_fp(input logic [FP_W-1:0] p);
    if (p == FP_W'(FIFO_D - 1)) return '0;
    return p + FP_W'(1);
  endfunction

  assign streaming   = (state_q == ST_STREAMING);
  assign restart_evt = streaming && bus.restart_in && !bus.load_valid_in;
  assign pop         = streaming && bus.consumed_in && head_valid_q && !bus.restart_in && !bus.load_valid_in;
  assign wr_addr     = (state_q == ST_LOADING) ? wr_ptr_q : '0;
  assign ret_data    = pipe_data_q[L-1];
  assign ret_idx     = pipe_idx_q[L-1];
  // Reads tagged with an older generation belong to a flushed stream and are dropped on return.
  assign ret_ok      = pipe_vld_q[L-1] && (pipe_gen_q[L-1] == gen_q);
  // A restart always issues the read of block 0 in its own cycle, so block 0 surfaces at restart+L+1.
  assign issue       = streaming && !bus.load_valid_in &&
                       (bus.restart_in ||
                        (int'(head_valid_q) + int'(fifo_cnt_q) + int'(inflight_q) < PREFETCH_DEPTH));
  assign issue_addr  = restart_evt ? '0 : rd_addr_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_done_d  = load_done_q;
    rd_addr_d    = rd_addr_q;
    gen_d        = gen_q;
    inflight_d   = inflight_q;
    head_data_d  = head_data_q;
    head_idx_d   = head_idx_q;
    head_valid_d = head_valid_q;
    fifo_data_d  = fifo_data_q;
    fifo_idx_d   = fifo_idx_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_cnt_d   = fifo_cnt_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;

    if (bus.load_valid_in) begin
      if (wr_addr == IDX_W'(NUM_BLOCKS - 1)) begin
        state_d     = ST_STREAMING;
        load_done_d = 1'b1;
        wr_ptr_d    = '0;
      end else begin
        state_d     = ST_LOADING;
        load_done_d = 1'b0;
        wr_ptr_d    = wr_addr + IDX_W'(1);
      end
      if (streaming) gen_d = ~gen_q;
      rd_addr_d    = '0;
      inflight_d   = '0;
      head_valid_d = 1'b0;
      fifo_rd_d    = '0;
      fifo_wr_d    = '0;
      fifo_cnt_d   = '0;
    end else if (restart_evt) begin
      gen_d        = ~gen_q;
      rd_addr_d    = next_addr('0);
      inflight_d   = CNT_W'(1);
      head_valid_d = 1'b0;
      fifo_rd_d    = '0;
      fifo_wr_d    = '0;
      fifo_cnt_d   = '0;
    end else if (streaming) begin
      // Head refills from the ring first, else straight from a returning read.
      if (!head_valid_q || pop) begin
        if (fifo_cnt_q != '0) begin
          head_data_d  = fifo_data_q[fifo_rd_q];
          head_idx_d   = fifo_idx_q[fifo_rd_q];
          head_valid_d = 1'b1;
          fifo_pop     = 1'b1;
          fifo_push    = ret_ok;
        end else if (ret_ok) begin
          head_data_d  = ret_data;
          head_idx_d   = ret_idx;
          head_valid_d = 1'b1;
        end else begin
          head_valid_d = 1'b0;
        end
      end else begin
        fifo_push = ret_ok;
      end
      if (fifo_push) begin
        fifo_data_d[fifo_wr_q] = ret_data;
        fifo_idx_d[fifo_wr_q]  = ret_idx;
        fifo_wr_d              = next_fp(fifo_wr_q);
      end
      if (fifo_pop) fifo_rd_d = next_fp(fifo_rd_q);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret_ok);
      if (issue) rd_addr_d = next_addr(rd_addr_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      load_done_q  <= 1'b0;
      rd_addr_q    <= '0;
      gen_q        <= 1'b0;
      inflight_q   <= '0;
      head_data_q  <= '0;
      head_idx_q   <= '0;
      head_valid_q <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_idx_q   <= '{default: '0};
      fifo_rd_q    <= '0;
      fifo_wr_q    <= '0;
      fifo_cnt_q   <= '0;
      pipe_vld_q   <= '{default: 1'b0};
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_done_q  <= load_done_d;
      rd_addr_q    <= rd_addr_d;
      gen_q        <= gen_d;
      inflight_q   <= inflight_d;
      head_data_q  <= head_data_d;
      head_idx_q   <= head_idx_d;
      head_valid_q <= head_valid_d;
      fifo_data_q  <= fifo_data_d;
      fifo_idx_q   <= fifo_idx_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < L; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // BRAM plus its read pipeline; no reset so it maps onto block RAM and its output registers.
  always_ff @(posedge clk_in) begin
    if (bus.load_valid_in) mem_q[wr_addr] <= bus.load_block_in;
    pipe_data_q[0] <= mem_q[issue_addr];
    pipe_idx_q[0]  <= issue_addr;
    pipe_gen_q[0]  <= gen_d;
    for (int i = 1; i < L; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_idx_q[i]  <= pipe_idx_q[i-1];
      pipe_gen_q[i]  <= pipe_gen_q[i-1];
    end
  end

  assign bus.load_done_out   = load_done_q;
  assign bus.block_out       = head_data_q;
  assign bus.block_valid_out = head_valid_q;
  assign bus.block_index_out = head_idx_q;
  assign bus.state_dbg_out   = state_q;

`ifdef MONTGOMERY_CONSTANT_STREAMER_UNDERFLOW_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_in) begin
    if (rst_in || bus.restart_in) begin
      err_q <= 1'b0;
    end else if (bus.consumed_in && !head_valid_q) begin
      err_q <= 1'b1;
      $error("montgomery_constant_streamer: consume while head block invalid");
    end
  end
  assign bus.underflow_err_out = err_q;
`else
  assign bus.underflow_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_montgomery_constant_streamer.sv
// Self-checking bench for montgomery_constant_streamer with a 4-block constant and a queue-based
// reference of the expected head sequence (block i of the constant, wrapping modulo NUM_BLOCKS).
module tb_montgomery_constant_streamer;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int IW = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  montgomery_constant_streamer_if #(.REGISTER_SIZE(W), .NUM_BLOCKS(N)) bus ();

  montgomery_constant_streamer #(
    .REGISTER_SIZE(W), .NUM_BLOCKS(N), .BRAM_LATENCY(L), .PREFETCH_DEPTH(D)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  logic [W-1:0] model_mem [N];
  logic [W-1:0] exp_q [$];
  int           exp_idx;
  int           check_count = 0;
  int           pass_count  = 0;
  logic         exp_err_en;

  // ---------------- reference model ----------------
  // After a rewind the head walks the constant 0,1,..,N-1,0,... one step per accepted consume.
  task automatic model_rewind();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(model_mem[i % N]);
    exp_idx = 0;
  endtask

  task automatic model_consume();
    void'(exp_q.pop_front());
    exp_idx = (exp_idx + 1) % N;
    exp_q.push_back(model_mem[(exp_idx + 63) % N]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    bus.load_valid_in = 1'b0;
    bus.load_block_in = '0;
    bus.restart_in    = 1'b0;
    bus.consumed_in   = 1'b0;
  endtask

  task automatic load_words(input int first);
    for (int i = first; i < N; i++) begin
      bus.load_valid_in = 1'b1;
      bus.load_block_in = model_mem[i];
      step();
    end
    bus.load_valid_in = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst_in = 1'b1;
    repeat (3) step();
    check_count++;
    if (bus.load_done_out !== 1'b0) $display("FAIL reset_load_done: got %0b expected 0", bus.load_done_out);
    else pass_count++;
    check_count++;
    if (bus.block_valid_out !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", bus.block_valid_out);
    else pass_count++;
    check_count++;
    if (bus.block_out !== '0) $display("FAIL reset_block: got %0h expected 0", bus.block_out);
    else pass_count++;
    check_count++;
    if (bus.block_index_out !== '0) $display("FAIL reset_index: got %0d expected 0", bus.block_index_out);
    else pass_count++;
    check_count++;
    if (bus.underflow_err_out !== 1'b0) $display("FAIL reset_err: got %0b expected 0", bus.underflow_err_out);
    else pass_count++;
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_load_restart();
    for (int i = 0; i < N; i++) model_mem[i] = 32'hA0 + i;
    load_words(0);
    check_count++;
    if (bus.load_done_out !== 1'b1) $display("FAIL load_done: got %0b expected 1", bus.load_done_out);
    else pass_count++;
    repeat (6) step();
    bus.restart_in = 1'b1;
    step();
    bus.restart_in = 1'b0;
    check_count++;
    if (bus.block_valid_out !== 1'b0) $display("FAIL restart_p1_valid: got %0b expected 0", bus.block_valid_out);
    else pass_count++;
    step();
    check_count++;
    if (bus.block_valid_out !== 1'b0) $display("FAIL restart_p2_valid: got %0b expected 0", bus.block_valid_out);
    else pass_count++;
    step();
    model_rewind();
    check_count++;
    if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(exp_idx))
      $display("FAIL restart_p3_head: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d",
               bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0], exp_idx);
    else pass_count++;
    check_count++;
    if (bus.load_done_out !== 1'b1) $display("FAIL load_done_hold: got %0b expected 1", bus.load_done_out);
    else pass_count++;
  endtask

  task automatic test_consume_every_cycle();
    repeat (3) step();
    for (int i = 0; i < 11; i++) begin
      check_count++;
      if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(exp_idx))
        $display("FAIL every_cycle[%0d]: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d", i,
                 bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0], exp_idx);
      else pass_count++;
      bus.consumed_in = (i < 10);
      step();
      if (i < 10) model_consume();
    end
    bus.consumed_in = 1'b0;
  endtask

  task automatic test_random_gaps();
    logic c;
    for (int i = 0; i < 30; i++) begin
      check_count++;
      if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(exp_idx))
        $display("FAIL gaps[%0d]: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d", i,
                 bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0], exp_idx);
      else pass_count++;
      c = 1'($urandom_range(0, 1));
      bus.consumed_in = c;
      step();
      if (c) model_consume();
    end
    bus.consumed_in = 1'b0;
  endtask

  task automatic test_restart_with_consume();
    for (int i = 0; i < N; i++) begin
      if (exp_idx != 2) begin
        bus.consumed_in = 1'b1;
        step();
        model_consume();
      end
    end
    bus.consumed_in = 1'b0;
    check_count++;
    if (bus.block_out !== model_mem[2] || bus.block_index_out !== IW'(2))
      $display("FAIL pre_restart_head: got d=%0h i=%0d expected d=%0h i=2",
               bus.block_out, bus.block_index_out, model_mem[2]);
    else pass_count++;
    bus.restart_in  = 1'b1;
    bus.consumed_in = 1'b1;
    step();
    bus.restart_in  = 1'b0;
    bus.consumed_in = 1'b0;
    check_count++;
    if (bus.block_valid_out !== 1'b0) $display("FAIL rc_p1_valid: got %0b expected 0", bus.block_valid_out);
    else pass_count++;
    repeat (2) step();
    model_rewind();
    check_count++;
    if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(0))
      $display("FAIL rc_p3_head: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=0",
               bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0]);
    else pass_count++;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      check_count++;
      if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(exp_idx))
        $display("FAIL rc_stream[%0d]: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d", i,
                 bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0], exp_idx);
      else pass_count++;
      bus.consumed_in = 1'b1;
      step();
      model_consume();
    end
    bus.consumed_in = 1'b0;
  endtask

  task automatic test_underflow();
    bus.restart_in = 1'b1;
    step();
    bus.restart_in  = 1'b0;
    bus.consumed_in = 1'b1;
    step();
    bus.consumed_in = 1'b0;
    check_count++;
    if (bus.underflow_err_out !== exp_err_en)
      $display("FAIL underflow_set: got %0b expected %0b", bus.underflow_err_out, exp_err_en);
    else pass_count++;
    step();
    model_rewind();
    check_count++;
    if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(0))
      $display("FAIL underflow_head: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=0",
               bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0]);
    else pass_count++;
    check_count++;
    if (bus.underflow_err_out !== exp_err_en)
      $display("FAIL underflow_sticky: got %0b expected %0b", bus.underflow_err_out, exp_err_en);
    else pass_count++;
    bus.restart_in = 1'b1;
    step();
    bus.restart_in = 1'b0;
    check_count++;
    if (bus.underflow_err_out !== 1'b0) $display("FAIL underflow_clear: got %0b expected 0", bus.underflow_err_out);
    else pass_count++;
    repeat (5) step();
    model_rewind();
  endtask

  task automatic test_reload(input logic randomize);
    logic c;
    for (int i = 0; i < N; i++) model_mem[i] = randomize ? $urandom : (32'hB0 + i);
    // First block of the reload collides with restart and consume; the load must win.
    bus.load_valid_in = 1'b1;
    bus.load_block_in = model_mem[0];
    bus.restart_in    = 1'b1;
    bus.consumed_in   = 1'b1;
    step();
    bus.restart_in  = 1'b0;
    bus.consumed_in = 1'b0;
    check_count++;
    if (bus.block_valid_out !== 1'b0 || bus.load_done_out !== 1'b0)
      $display("FAIL reload_flush: got v=%0b done=%0b expected v=0 done=0", bus.block_valid_out, bus.load_done_out);
    else pass_count++;
    load_words(1);
    check_count++;
    if (bus.load_done_out !== 1'b1) $display("FAIL reload_done: got %0b expected 1", bus.load_done_out);
    else pass_count++;
    bus.restart_in = 1'b1;
    step();
    bus.restart_in = 1'b0;
    repeat (2) step();
    model_rewind();
    check_count++;
    if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(0))
      $display("FAIL reload_head: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=0",
               bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0]);
    else pass_count++;
    repeat (3) step();
    for (int i = 0; i < 16; i++) begin
      check_count++;
      if (bus.block_valid_out !== 1'b1 || bus.block_out !== exp_q[0] || bus.block_index_out !== IW'(exp_idx))
        $display("FAIL reload_stream[%0d]: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d", i,
                 bus.block_valid_out, bus.block_out, bus.block_index_out, exp_q[0], exp_idx);
      else pass_count++;
      c = 1'($urandom_range(0, 1));
      bus.consumed_in = c;
      step();
      if (c) model_consume();
    end
    bus.consumed_in = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rst_in          = 1'b1;
    bus.consumed_in = 1'b1;
    step();
    rst_in          = 1'b0;
    bus.consumed_in = 1'b0;
    check_count++;
    if (bus.block_valid_out !== 1'b0 || bus.load_done_out !== 1'b0 || bus.block_out !== '0 ||
        bus.block_index_out !== '0)
      $display("FAIL midreset_outputs: got v=%0b done=%0b d=%0h i=%0d expected all 0",
               bus.block_valid_out, bus.load_done_out, bus.block_out, bus.block_index_out);
    else pass_count++;
    bus.restart_in = 1'b1;
    step();
    bus.restart_in = 1'b0;
    repeat (5) step();
    check_count++;
    if (bus.block_valid_out !== 1'b0 || bus.load_done_out !== 1'b0)
      $display("FAIL midreset_needs_reload: got v=%0b done=%0b expected v=0 done=0",
               bus.block_valid_out, bus.load_done_out);
    else pass_count++;
  endtask

  initial begin
`ifdef MONTGOMERY_CONSTANT_STREAMER_UNDERFLOW_CHECK_EN
    exp_err_en = 1'b1;
`else
    exp_err_en = 1'b0;
`endif
    test_reset();
    test_load_restart();
    test_consume_every_cycle();
    test_random_gaps();
    test_restart_with_consume();
    test_underflow();
    test_reload(1'b0);
    test_reload(1'b1);
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
